// File: rtl/knn_mem_arbiter_pkg.sv
// Shared definitions for the KNN memory arbiter: requester ids, lock FSM
// encoding and small id-decoding helpers.
package knn_mem_arbiter_pkg;

    localparam logic REQ_KNN  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    function automatic logic [1:0] id_onehot(input logic id);
        return (id == REQ_HOST) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] own_state(input logic id);
        return (id == REQ_HOST) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/knn_mem_arbiter_rd_tag_pipe.sv
// Latency-matched {valid, id} shift register. A tag pushed alongside an
// issued read emerges DEPTH cycles later, aligned with the memory data.
module knn_rd_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic push_vld,
    input  logic push_id,
    output logic pop_vld,
    output logic pop_id
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] id_q, id_d;

    // Shift one stage per cycle, new tag enters at bit 0.
    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], push_vld};
        id_d  = {id_q[DEPTH-2:0], push_id};
    end

    // Valid bits are cleared on reset so in-flight reads are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Id bits are only meaningful under their valid bit.
    always_ff @(posedge clk) begin
        id_q <= id_d;
    end

    assign pop_vld = vld_q[DEPTH-1];
    assign pop_id  = id_q[DEPTH-1];

endmodule

// File: rtl/knn_mem_arbiter.sv
// Shares one fixed-latency memory port between the KNN controller
// (requester 0) and the host load/unload engine (requester 1). Round-robin
// arbitration with per-requester lock; read data is routed back by tag.
module knn_mem_arbiter
    import knn_mem_arbiter_pkg::*;
#(
    parameter int W      = 32,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_rd,
    input  logic [1:0]        req_wr,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [W-1:0]      req_wdata0,
    input  logic [W-1:0]      req_wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [W-1:0]      rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W-1:0]      mem_wdata,
    input  logic [W-1:0]      mem_rdata,
    output logic              err_rw
);

    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [W-1:0]      rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0]      mem_wdata_q, mem_wdata_d;
    logic              err_rw_q, err_rw_d;
    logic              rr_q, rr_d;
    logic [1:0]        lock_q, lock_d;

    logic [1:0] elig;
    logic       rr_other;
    logic       sel_vld;
    logic       sel_id;
    logic       sel_rd;
    logic       sel_wr;
    logic       tag_vld;
    logic       tag_id;

    assign rr_other = ~rr_q;

    // Pick at most one requester; the grant-cycle mask prevents re-issuing a
    // request that is still held while its grant is visible.
    always_comb begin
        elig    = (req_rd | req_wr) & ~gnt_q;
        sel_vld = 1'b0;
        sel_id  = REQ_KNN;
        case (lock_q)
            ST_OWN0: begin
                sel_vld = elig[REQ_KNN];
                sel_id  = REQ_KNN;
            end
            ST_OWN1: begin
                sel_vld = elig[REQ_HOST];
                sel_id  = REQ_HOST;
            end
            default: begin
                if (elig[rr_q]) begin
                    sel_vld = 1'b1;
                    sel_id  = rr_q;
                end else if (elig[rr_other]) begin
                    sel_vld = 1'b1;
                    sel_id  = rr_other;
                end
            end
        endcase
        // A simultaneous rd+wr is treated as a write; the read is dropped.
        sel_wr = req_wr[sel_id];
        sel_rd = req_rd[sel_id] & ~sel_wr;
    end

    // Next values for the memory-side strobes, pointer, lock FSM and error.
    always_comb begin
        gnt_d       = sel_vld ? id_onehot(sel_id) : 2'b00;
        mem_read_d  = sel_vld & sel_rd;
        mem_write_d = sel_vld & sel_wr;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (sel_vld) begin
            mem_addr_d = (sel_id == REQ_HOST) ? req_addr1 : req_addr0;
        end
        if (sel_vld && sel_wr) begin
            mem_wdata_d = (sel_id == REQ_HOST) ? req_wdata1 : req_wdata0;
        end
        rr_d     = sel_vld ? ~sel_id : rr_q;
        err_rw_d = err_rw_q | (|(req_rd & req_wr));

        lock_d = lock_q;
        case (lock_q)
            ST_OWN0: if (!req_lock[REQ_KNN])  lock_d = ST_FREE;
            ST_OWN1: if (!req_lock[REQ_HOST]) lock_d = ST_FREE;
            default: begin
                lock_d = ST_FREE;
                if (sel_vld && req_lock[sel_id]) lock_d = own_state(sel_id);
            end
        endcase
    end

    knn_rd_tag_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .push_vld(sel_vld & sel_rd),
        .push_id (sel_id),
        .pop_vld (tag_vld),
        .pop_id  (tag_id)
    );

    // Returned data is captured when the matching tag leaves the pipe.
    always_comb begin
        rvalid_d = tag_vld ? id_onehot(tag_id) : 2'b00;
        rdata_d  = tag_vld ? mem_rdata : rdata_q;
    end

    // All architectural state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            rdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_rw_q    <= 1'b0;
            rr_q        <= REQ_KNN;
            lock_q      <= ST_FREE;
        end else begin
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_rw_q    <= err_rw_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
        end
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err_rw    = err_rw_q;

endmodule

// File: tb/tb_knn_mem_arbiter.sv
// Directed bench for knn_mem_arbiter with a small fixed-latency memory model.
module tb_knn_mem_arbiter;

    localparam int W      = 32;
    localparam int ADDR_W = 16;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_rd = 2'b00;
    logic [1:0]        req_wr = 2'b00;
    logic [1:0]        req_lock = 2'b00;
    logic [ADDR_W-1:0] req_addr0 = '0;
    logic [ADDR_W-1:0] req_addr1 = '0;
    logic [W-1:0]      req_wdata0 = '0;
    logic [W-1:0]      req_wdata1 = '0;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [W-1:0]      rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [W-1:0]      mem_wdata;
    logic [W-1:0]      mem_rdata;
    logic              err_rw;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    knn_mem_arbiter #(
        .W(W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err_rw(err_rw)
    );

    // Memory model: 256 words, data RD_LAT cycles after mem_read is seen.
    // Contents are preloaded whenever reset is held: word a = 0xCAFE00aa,
    // except address 0x10 which holds 0xCAFE0001.
    logic [W-1:0] mem [0:255];
    logic         rd_vld_p [0:RD_LAT-1];
    logic [7:0]   rd_adr_p [0:RD_LAT-1];

    always @(posedge clk) begin
        rd_vld_p[0] <= mem_read;
        rd_adr_p[0] <= mem_addr[7:0];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_p[i] <= rd_vld_p[i-1];
            rd_adr_p[i] <= rd_adr_p[i-1];
        end
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= {16'hCAFE, 8'h00, i[7:0]};
            mem[8'h10] <= 32'hCAFE0001;
        end else if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    assign mem_rdata = rd_vld_p[RD_LAT-1] ? mem[rd_adr_p[RD_LAT-1]] : '0;

    task automatic do_reset();
        @(negedge clk);
        req_rd = 2'b00; req_wr = 2'b00; req_lock = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata, err_rw} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got gnt=%b rvalid=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h err=%b, want all zero",
                     gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata, err_rw);
        end
        // Idle cycle with no requests: still nothing issued.
        @(negedge clk);
        total++;
        if ({gnt, mem_read, mem_write} !== 4'b0) begin
            bad++;
            $display("FAIL reset_idle: got gnt=%b rd=%b wr=%b, want 0", gnt, mem_read, mem_write);
        end
    endtask

    task automatic test_single_read();
        logic [1:0]  e_rv [1:5];
        do_reset();
        e_rv = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        req_rd = 2'b01; req_addr0 = 16'h0010;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== ((k == 1) ? 2'b01 : 2'b00) || mem_read !== (k == 1) || mem_write !== 1'b0) begin
                bad++;
                $display("FAIL single_gnt[%0d]: got gnt=%b rd=%b wr=%b", k, gnt, mem_read, mem_write);
            end
            total++;
            if (rvalid !== e_rv[k]) begin
                bad++;
                $display("FAIL single_rvalid[%0d]: got %b want %b", k, rvalid, e_rv[k]);
            end
            if (k == 1) begin
                total++;
                if (mem_addr !== 16'h0010) begin
                    bad++;
                    $display("FAIL single_addr: got %h want 0010", mem_addr);
                end
                req_rd = 2'b00;
            end
            if (k == 4) begin
                total++;
                if (rdata !== 32'hCAFE0001) begin
                    bad++;
                    $display("FAIL single_rdata: got %h want cafe0001", rdata);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0]  e_gnt [1:8];
        logic [15:0] e_adr [1:8];
        logic [1:0]  e_rv  [1:8];
        logic [31:0] e_dat [1:8];
        do_reset();
        e_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        e_adr = '{16'h20, 16'h30, 16'h24, 16'h34, 16'h34, 16'h34, 16'h34, 16'h34};
        e_rv  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        e_dat = '{32'h0, 32'h0, 32'h0, 32'hCAFE0020, 32'hCAFE0030, 32'hCAFE0024, 32'hCAFE0034, 32'h0};
        req_rd = 2'b11; req_addr0 = 16'h20; req_addr1 = 16'h30;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== e_gnt[k] || mem_read !== (e_gnt[k] != 2'b00) || mem_addr !== e_adr[k]) begin
                bad++;
                $display("FAIL contend_gnt[%0d]: got gnt=%b rd=%b addr=%h want gnt=%b addr=%h",
                         k, gnt, mem_read, mem_addr, e_gnt[k], e_adr[k]);
            end
            total++;
            if (rvalid !== e_rv[k] || (e_rv[k] != 2'b00 && rdata !== e_dat[k])) begin
                bad++;
                $display("FAIL contend_rv[%0d]: got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                         k, rvalid, rdata, e_rv[k], e_dat[k]);
            end
            case (k)
                1: req_addr0 = 16'h24;
                2: req_addr1 = 16'h34;
                3: req_rd[0] = 1'b0;
                4: req_rd[1] = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_lock_burst();
        logic [1:0]  e_gnt [1:9];
        logic [15:0] e_adr [1:9];
        do_reset();
        e_gnt = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        e_adr = '{16'h40, 16'h40, 16'h41, 16'h41, 16'h42, 16'h42, 16'h43, 16'h50, 16'h50};
        req_rd = 2'b11; req_lock = 2'b01; req_addr0 = 16'h40; req_addr1 = 16'h50;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            total++;
            if (gnt !== e_gnt[k] || mem_addr !== e_adr[k]) begin
                bad++;
                $display("FAIL lock_gnt[%0d]: got gnt=%b addr=%h want gnt=%b addr=%h",
                         k, gnt, mem_addr, e_gnt[k], e_adr[k]);
            end
            case (k)
                1: req_addr0 = 16'h41;
                3: req_addr0 = 16'h42;
                5: req_addr0 = 16'h43;
                6: req_lock  = 2'b00;
                7: req_rd[0] = 1'b0;
                8: req_rd[1] = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_write_read();
        do_reset();
        req_wr = 2'b10; req_addr1 = 16'h0055; req_wdata1 = 32'h12345678;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            case (k)
                1: begin
                    total++;
                    if (gnt !== 2'b10 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
                        mem_addr !== 16'h0055 || mem_wdata !== 32'h12345678) begin
                        bad++;
                        $display("FAIL wr_issue: got gnt=%b wr=%b rd=%b addr=%h wdata=%h",
                                 gnt, mem_write, mem_read, mem_addr, mem_wdata);
                    end
                    req_wr = 2'b00; req_rd = 2'b10; req_wdata1 = 32'h0;
                end
                2: begin
                    total++;
                    if (gnt !== 2'b00 || mem_write !== 1'b0 || mem_addr !== 16'h0055 ||
                        mem_wdata !== 32'h12345678) begin
                        bad++;
                        $display("FAIL wr_hold: got gnt=%b wr=%b addr=%h wdata=%h",
                                 gnt, mem_write, mem_addr, mem_wdata);
                    end
                end
                3: begin
                    total++;
                    if (gnt !== 2'b10 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 16'h0055) begin
                        bad++;
                        $display("FAIL rd_issue: got gnt=%b rd=%b wr=%b addr=%h", gnt, mem_read, mem_write, mem_addr);
                    end
                    req_rd = 2'b00;
                end
                default: ;
            endcase
            total++;
            if (rvalid !== ((k == 6) ? 2'b10 : 2'b00)) begin
                bad++;
                $display("FAIL wr_rd_rvalid[%0d]: got %b", k, rvalid);
            end
            if (k == 6) begin
                total++;
                if (rdata !== 32'h12345678) begin
                    bad++;
                    $display("FAIL wr_rd_data: got %h want 12345678", rdata);
                end
            end
        end
    endtask

    task automatic test_rw_err();
        do_reset();
        total++;
        if (err_rw !== 1'b0) begin
            bad++;
            $display("FAIL err_init: got %b want 0", err_rw);
        end
        req_rd = 2'b01; req_wr = 2'b01; req_addr0 = 16'h0066; req_wdata0 = 32'hA5A5A5A5;
        @(negedge clk);
        total++;
        if (gnt !== 2'b01 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 32'hA5A5A5A5 || err_rw !== 1'b1) begin
            bad++;
            $display("FAIL err_issue: got gnt=%b wr=%b rd=%b wdata=%h err=%b",
                     gnt, mem_write, mem_read, mem_wdata, err_rw);
        end
        req_rd = 2'b00; req_wr = 2'b00;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            total++;
            if (err_rw !== 1'b1 || rvalid !== 2'b00) begin
                bad++;
                $display("FAIL err_sticky[%0d]: got err=%b rvalid=%b want 1/00", k, err_rw, rvalid);
            end
        end
    endtask

    // Runs straight after test_rw_err: err_rw is 1 and rr points at requester 1.
    task automatic test_reset_midflight();
        req_rd = 2'b11; req_addr0 = 16'h0070; req_addr1 = 16'h0071;
        @(negedge clk);
        total++;
        if (gnt !== 2'b10) begin
            bad++;
            $display("FAIL mid_gnt1: got %b want 10", gnt);
        end
        req_rd[1] = 1'b0;
        @(negedge clk);
        total++;
        if (gnt !== 2'b01) begin
            bad++;
            $display("FAIL mid_gnt0: got %b want 01", gnt);
        end
        req_rd = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata, err_rw} !== '0) begin
            bad++;
            $display("FAIL mid_reset_vals: got gnt=%b rvalid=%b rdata=%h rd=%b wr=%b addr=%h wdata=%h err=%b",
                     gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_wdata, err_rw);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (rvalid !== 2'b00 || gnt !== 2'b00) begin
                bad++;
                $display("FAIL mid_no_rvalid[%0d]: got rvalid=%b gnt=%b", k, rvalid, gnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lock_burst();
        test_write_read();
        test_rw_err();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
